// File: rtl/pcie_tlp_pkg.sv
// Shared TLP definitions: traffic classes, fmt/type encodings, header struct
// and the header-to-credit-class decode used by both TX and RX schedulers.
package pcie_tlp_pkg;

    typedef enum logic [1:0] {
        POSTED     = 2'd0,
        NON_POSTED = 2'd1,
        COMPLETION = 2'd2
    } tlp_class_e;

    localparam int NUM_CLASSES = 3;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;

    localparam logic [4:0] TYPE_MEM  = 5'b00000;
    localparam logic [4:0] TYPE_CFG0 = 5'b00100;
    localparam logic [4:0] TYPE_CPL  = 5'b01010;

    // {fmt, type} pairs of the TLPs this block schedules
    localparam logic [7:0] MWR    = {FMT_3DW_DATA,   TYPE_MEM};
    localparam logic [7:0] MRD    = {FMT_3DW_NODATA, TYPE_MEM};
    localparam logic [7:0] CFGRD0 = {FMT_3DW_NODATA, TYPE_CFG0};
    localparam logic [7:0] CFGWR0 = {FMT_3DW_DATA,   TYPE_CFG0};
    localparam logic [7:0] CPL    = {FMT_3DW_NODATA, TYPE_CPL};
    localparam logic [7:0] CPLD   = {FMT_3DW_DATA,   TYPE_CPL};

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic [2:0]  tc;
        logic [8:0]  length;
        logic [15:0] requestID;
    } tlp_hdr_t;

    // Memory writes (3DW or 4DW, fmt[1] set) are posted; any completion type
    // uses completion credits; everything else is non-posted.
    function automatic tlp_class_e class_of(input logic [2:0] fmt, input logic [4:0] typ);
        if (typ == TYPE_MEM && fmt[1]) return POSTED;
        if (typ == TYPE_CPL)           return COMPLETION;
        return NON_POSTED;
    endfunction

endpackage

// File: rtl/pcie_rr_arb.sv
// Combinational round-robin pick: first eligible index at or after ptr_i,
// wrapping modulo N. Shared by the TX arbiter and the RX completion scheduler.
module pcie_rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin : pick
        int cand;
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            // Conditional subtract instead of % keeps non-power-of-two N cheap
            cand = int'(ptr_i) + i;
            if (cand >= N) cand = cand - N;
            if (!found_o && eligible_i[IW'(cand)]) begin
                found_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/pcie_tlp_tx_arbiter.sv
// Transmit-side TLP scheduler: credit-gated round-robin over NUM_REQ requesters,
// holding each grant for a whole packet and muxing the owner's beats straight through.
module pcie_tlp_tx_arbiter
    import pcie_tlp_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int PH_INIT    = 8,
    parameter int NPH_INIT   = 8,
    parameter int CPLH_INIT  = 8,
    localparam int GW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*3-1:0]          req_fmt_i,
    input  logic [NUM_REQ*5-1:0]          req_type_i,
    input  logic [NUM_REQ*3-1:0]          req_tc_i,
    input  logic [NUM_REQ*9-1:0]          req_length_i,
    input  logic [NUM_REQ*16-1:0]         req_requestID_i,
    input  logic [NUM_REQ*32-1:0]         req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [2:0]                    credit_ret_i,
    output logic                          tlp_valid_o,
    input  logic                          tlp_ready_i,
    output logic                          tlp_last_o,
    output logic [2:0]                    header_fmt_o,
    output logic [4:0]                    header_type_o,
    output logic [2:0]                    header_tc_o,
    output logic [8:0]                    header_length_o,
    output logic [15:0]                   header_requestID_o,
    output logic [31:0]                   addr_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [GW-1:0]                 grant_o
);

    typedef enum logic {IDLE, XFER} state_e;

    state_e                 state_q;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          rr_ptr_q;
    logic [7:0]             credit_q [NUM_CLASSES];
    logic [7:0]             credit_d [NUM_CLASSES];

    tlp_class_e             req_class [NUM_REQ];
    logic [NUM_REQ-1:0]     eligible;
    logic                   arb_found;
    logic [GW-1:0]          arb_idx;
    logic                   start_pkt;
    logic                   pkt_done;
    logic [NUM_CLASSES-1:0] credit_dec;
    logic [GW-1:0]          rr_ptr_next;
    tlp_hdr_t               out_hdr;

    always_comb begin
        for (int n = 0; n < NUM_REQ; n++) begin
            req_class[n] = class_of(req_fmt_i[n*3 +: 3], req_type_i[n*5 +: 5]);
            eligible[n]  = req_valid_i[n] && (credit_q[req_class[n]] != 8'd0);
        end
    end

    pcie_rr_arb #(.N(NUM_REQ)) u_rr_arb (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .found_o    (arb_found),
        .idx_o      (arb_idx)
    );

    assign start_pkt   = (state_q == IDLE) && arb_found;
    assign pkt_done    = (state_q == XFER) && req_valid_i[grant_q] && tlp_ready_i
                         && req_last_i[grant_q];
    assign rr_ptr_next = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // A same-cycle spend and return on one class cancel; returns saturate at 255
    always_comb begin
        credit_dec = '0;
        if (start_pkt) credit_dec[req_class[arb_idx]] = 1'b1;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            credit_d[c] = credit_q[c];
            if (credit_dec[c] && !credit_ret_i[c])
                credit_d[c] = credit_q[c] - 8'd1;
            else if (credit_ret_i[c] && !credit_dec[c] && credit_q[c] != 8'hFF)
                credit_d[c] = credit_q[c] + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is
    // synchronous, so it is simply the first branch inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            credit_q[0] <= 8'(PH_INIT);
            credit_q[1] <= 8'(NPH_INIT);
            credit_q[2] <= 8'(CPLH_INIT);
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++) credit_q[c] <= credit_d[c];
            case (state_q)
                IDLE: if (arb_found) begin
                    state_q <= XFER;
                    grant_q <= arb_idx;
                end
                XFER: if (pkt_done) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= rr_ptr_next;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default up front, so no path infers a latch.
    always_comb begin
        req_ready_o = '0;
        tlp_valid_o = 1'b0;
        tlp_last_o  = 1'b0;
        out_hdr     = '0;
        addr_o      = '0;
        data_o      = '0;
        if (state_q == XFER) begin
            tlp_valid_o          = req_valid_i[grant_q];
            tlp_last_o           = req_last_i[grant_q];
            req_ready_o[grant_q] = tlp_ready_i;
            out_hdr.fmt          = req_fmt_i[grant_q*3 +: 3];
            out_hdr.typ          = req_type_i[grant_q*5 +: 5];
            out_hdr.tc           = req_tc_i[grant_q*3 +: 3];
            out_hdr.length       = req_length_i[grant_q*9 +: 9];
            out_hdr.requestID    = req_requestID_i[grant_q*16 +: 16];
            addr_o               = req_addr_i[grant_q*32 +: 32];
            data_o               = req_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign header_fmt_o       = out_hdr.fmt;
    assign header_type_o      = out_hdr.typ;
    assign header_tc_o        = out_hdr.tc;
    assign header_length_o    = out_hdr.length;
    assign header_requestID_o = out_hdr.requestID;
    assign grant_o            = grant_q;

endmodule

// File: tb/tb_pcie_tlp_tx_arbiter.sv
// Bench for pcie_tlp_tx_arbiter: packet-queue requesters plus a transaction-level
// model (owner, pointer, credit counts) compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_pcie_tlp_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 128;
    localparam int GW      = 2;
    localparam int MAXP    = 256;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid_i, req_ready_o, req_last_i;
    logic [NUM_REQ*3-1:0]  req_fmt_i, req_tc_i;
    logic [NUM_REQ*5-1:0]  req_type_i;
    logic [NUM_REQ*9-1:0]  req_length_i;
    logic [NUM_REQ*16-1:0] req_requestID_i;
    logic [NUM_REQ*32-1:0] req_addr_i;
    logic [NUM_REQ*DW-1:0] req_data_i;
    logic [2:0]            credit_ret_i;
    logic                  tlp_valid_o, tlp_ready_i, tlp_last_o;
    logic [2:0]            header_fmt_o, header_tc_o;
    logic [4:0]            header_type_o;
    logic [8:0]            header_length_o;
    logic [15:0]           header_requestID_o;
    logic [31:0]           addr_o;
    logic [DW-1:0]         data_o;
    logic [GW-1:0]         grant_o;

    pcie_tlp_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .PH_INIT(8), .NPH_INIT(8), .CPLH_INIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_last_i(req_last_i),
        .req_fmt_i(req_fmt_i), .req_type_i(req_type_i), .req_tc_i(req_tc_i),
        .req_length_i(req_length_i), .req_requestID_i(req_requestID_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .credit_ret_i(credit_ret_i),
        .tlp_valid_o(tlp_valid_o), .tlp_ready_i(tlp_ready_i), .tlp_last_o(tlp_last_o),
        .header_fmt_o(header_fmt_o), .header_type_o(header_type_o), .header_tc_o(header_tc_o),
        .header_length_o(header_length_o), .header_requestID_o(header_requestID_o),
        .addr_o(addr_o), .data_o(data_o), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic [2:0]  tc;
        logic [8:0]  len;
        logic [15:0] rid;
        logic [31:0] addr;
        logic [DW-1:0] base;
        int          nbeats;
    } pkt_t;

    pkt_t pkts [NUM_REQ][MAXP];
    int   head [NUM_REQ];
    int   tail [NUM_REQ];
    int   cur_beat [NUM_REQ];
    bit   presenting [NUM_REQ];
    bit   rand_gaps;
    int   order_log [$];

    // Reference model: is a packet in flight, who owns the output, where the
    // rotation resumes, and how many header credits each class holds.
    bit   m_busy;
    int   m_owner;
    int   m_ptr;
    int   m_cred [3];

    int   n_checks;
    int   n_errors;
    int   cyc;
    bit   chk_en;

    function automatic int req_cls(input int r);
        logic [2:0] f;
        logic [4:0] t;
        f = req_fmt_i[r*3 +: 3];
        t = req_type_i[r*5 +: 5];
        if (t == 5'b00000 && f[1]) return 0;
        if (t == 5'b01010) return 2;
        return 1;
    endfunction

    task automatic push_pkt(input int n, input logic [2:0] fmt, input logic [4:0] typ,
                            input int nbeats, input logic [8:0] len, input logic [31:0] addr,
                            input logic [DW-1:0] base);
        pkt_t p;
        p.fmt = fmt; p.typ = typ; p.nbeats = nbeats; p.len = len; p.addr = addr; p.base = base;
        p.tc  = 3'($urandom);
        p.rid = 16'($urandom);
        pkts[n][tail[n] % MAXP] = p;
        tail[n]++;
    endtask

    task automatic flush_reqs();
        for (int n = 0; n < NUM_REQ; n++) begin
            head[n] = tail[n]; cur_beat[n] = 0; presenting[n] = 1'b0;
        end
        req_valid_i = '0;
    endtask

    task automatic drive_inputs();
        pkt_t p;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (!presenting[n] && head[n] != tail[n] && (!rand_gaps || $urandom_range(0, 3) != 0))
                presenting[n] = 1'b1;
            if (head[n] != tail[n]) begin
                p = pkts[n][head[n] % MAXP];
                req_fmt_i[n*3 +: 3]         = p.fmt;
                req_type_i[n*5 +: 5]        = p.typ;
                req_tc_i[n*3 +: 3]          = p.tc;
                req_length_i[n*9 +: 9]      = p.len;
                req_requestID_i[n*16 +: 16] = p.rid;
                req_addr_i[n*32 +: 32]      = p.addr;
                req_data_i[n*DW +: DW]      = p.base + DW'(cur_beat[n]);
                req_last_i[n]               = (cur_beat[n] == p.nbeats - 1);
            end else begin
                req_fmt_i[n*3 +: 3] = '0; req_type_i[n*5 +: 5] = '0; req_tc_i[n*3 +: 3] = '0;
                req_length_i[n*9 +: 9] = '0; req_requestID_i[n*16 +: 16] = '0;
                req_addr_i[n*32 +: 32] = '0; req_data_i[n*DW +: DW] = '0; req_last_i[n] = 1'b0;
            end
            req_valid_i[n] = presenting[n];
        end
    endtask

    task automatic compare_to_model();
        logic [NUM_REQ-1:0] e_ready;
        logic               e_valid, e_last;
        logic [67:0]        e_hdr;
        logic [DW-1:0]      e_data;
        e_ready = '0; e_valid = 1'b0; e_last = 1'b0; e_hdr = '0; e_data = '0;
        if (m_busy) begin
            e_valid          = req_valid_i[m_owner];
            e_last           = req_last_i[m_owner];
            e_ready[m_owner] = tlp_ready_i;
            e_hdr  = {req_fmt_i[m_owner*3 +: 3], req_type_i[m_owner*5 +: 5], req_tc_i[m_owner*3 +: 3],
                      req_length_i[m_owner*9 +: 9], req_requestID_i[m_owner*16 +: 16],
                      req_addr_i[m_owner*32 +: 32]};
            e_data = req_data_i[m_owner*DW +: DW];
        end
        n_checks++;
        if ({tlp_valid_o, tlp_last_o, req_ready_o, grant_o} !== {e_valid, e_last, e_ready, GW'(m_owner)}) begin
            n_errors++;
            $display("FAIL model_ctrl t=%0t {valid,last,ready,grant}: got %b want %b", $time,
                     {tlp_valid_o, tlp_last_o, req_ready_o, grant_o}, {e_valid, e_last, e_ready, GW'(m_owner)});
        end
        n_checks++;
        if ({header_fmt_o, header_type_o, header_tc_o, header_length_o, header_requestID_o, addr_o} !== e_hdr) begin
            n_errors++;
            $display("FAIL model_hdr t=%0t: got %h want %h", $time,
                     {header_fmt_o, header_type_o, header_tc_o, header_length_o, header_requestID_o, addr_o}, e_hdr);
        end
        n_checks++;
        if (data_o !== e_data) begin
            n_errors++;
            $display("FAIL model_data t=%0t: got %h want %h", $time, data_o, e_data);
        end
        n_checks++;
        if ({dut.credit_q[0], dut.credit_q[1], dut.credit_q[2]} !== {8'(m_cred[0]), 8'(m_cred[1]), 8'(m_cred[2])}) begin
            n_errors++;
            $display("FAIL model_credits t=%0t: got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                     dut.credit_q[0], dut.credit_q[1], dut.credit_q[2], m_cred[0], m_cred[1], m_cred[2]);
        end
    endtask

    // One clock: drive at the falling edge, compare, predict, then step the model.
    task automatic cycle(input logic rdy, input logic [2:0] ret);
        logic [NUM_REQ-1:0] hs;
        bit n_busy;
        int n_owner, n_ptr, win, r;
        int n_cred [3];
        tlp_ready_i  = rdy;
        credit_ret_i = ret;
        drive_inputs();
        #1;
        if (chk_en) compare_to_model();
        hs = req_valid_i & req_ready_o;
        n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_cred = m_cred;
        win = -1;
        if (rst) begin
            n_busy = 1'b0; n_owner = 0; n_ptr = 0; n_cred = '{8, 8, 8};
        end else begin
            if (!m_busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    r = (m_ptr + k) % NUM_REQ;
                    if (win < 0 && req_valid_i[r] && m_cred[req_cls(r)] > 0) win = r;
                end
                if (win >= 0) begin n_busy = 1'b1; n_owner = win; end
            end else if (req_valid_i[m_owner] && tlp_ready_i && req_last_i[m_owner]) begin
                n_busy = 1'b0;
                n_ptr  = (m_owner + 1) % NUM_REQ;
            end
            for (int c = 0; c < 3; c++) begin
                n_cred[c] = m_cred[c] + int'(ret[c]) - ((win >= 0 && req_cls(win) == c) ? 1 : 0);
                if (n_cred[c] > 255) n_cred[c] = 255;
            end
        end
        @(posedge clk);
        m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_cred = n_cred;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (hs[n]) begin
                presenting[n] = 1'b0;
                if (req_last_i[n]) begin
                    order_log.push_back(n);
                    head[n]++;
                    cur_beat[n] = 0;
                end else begin
                    cur_beat[n]++;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int budget, input string what);
        int k;
        k = 0;
        while (order_log.size() < n && k < budget) begin
            cycle(1'b1, 3'b000);
            k++;
        end
        n_checks++;
        if (order_log.size() < n) begin
            n_errors++;
            $display("FAIL %s_timeout: packets done %0d required %0d", what, order_log.size(), n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 3'b000);
        rst = 1'b0;
        flush_reqs();
        order_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        chk_en = 1'b0;
        cycle(1'b0, 3'b000);
        chk_en = 1'b1;
        cycle(1'b0, 3'b000);
        rst = 1'b0;
        n_checks++;
        if ({tlp_valid_o, tlp_last_o, req_ready_o, grant_o} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b required 00000000", {tlp_valid_o, tlp_last_o, req_ready_o, grant_o});
        end
        n_checks++;
        if ({dut.credit_q[0], dut.credit_q[1], dut.credit_q[2]} !== 24'h080808) begin
            n_errors++;
            $display("FAIL reset_credits: got %h required 080808", {dut.credit_q[0], dut.credit_q[1], dut.credit_q[2]});
        end
    endtask

    task automatic test_single_mwr();
        do_reset();
        push_pkt(0, 3'b010, 5'b00000, 1, 9'd4, 32'h0, {4{32'h01234567}});
        cycle(1'b0, 3'b000);
        n_checks++;
        if (tlp_valid_o !== 1'b1 || grant_o !== 2'd0 || tlp_last_o !== 1'b1) begin
            n_errors++;
            $display("FAIL mwr_latency: valid/grant/last got %b/%0d/%b required 1/0/1", tlp_valid_o, grant_o, tlp_last_o);
        end
        n_checks++;
        if (data_o !== {4{32'h01234567}} || addr_o !== 32'h0 || header_length_o !== 9'd4 || header_fmt_o !== 3'b010) begin
            n_errors++;
            $display("FAIL mwr_fields: data %h addr %h len %0d fmt %b", data_o, addr_o, header_length_o, header_fmt_o);
        end
        cycle(1'b1, 3'b000);
        n_checks++;
        if (dut.credit_q[0] !== 8'd7 || order_log.size() != 1) begin
            n_errors++;
            $display("FAIL mwr_ph_credit: got %0d (pkts %0d) required 7 (pkts 1)", dut.credit_q[0], order_log.size());
        end
    endtask

    task automatic test_round_robin();
        int c0;
        do_reset();
        for (int n = 0; n < NUM_REQ; n++)
            push_pkt(n, 3'b000, 5'b00000, 2, 9'd1, 32'h1000 * n, {$urandom, $urandom, $urandom, $urandom});
        c0 = cyc;
        run_until(4, 40, "rr");
        n_checks++;
        if (order_log.size() != 4 || order_log[0] != 0 || order_log[1] != 1 || order_log[2] != 2 || order_log[3] != 3) begin
            n_errors++;
            $display("FAIL rr_order: got %p required 0,1,2,3", order_log);
        end
        n_checks++;
        if (cyc - c0 != 12) begin
            n_errors++;
            $display("FAIL rr_cycles: got %0d required 12", cyc - c0);
        end
        n_checks++;
        if (dut.credit_q[1] !== 8'd4) begin
            n_errors++;
            $display("FAIL rr_nph_credit: got %0d required 4", dut.credit_q[1]);
        end
    endtask

    task automatic test_credit_block();
        do_reset();
        for (int i = 0; i < 7; i++) push_pkt(3, 3'b010, 5'b00000, 1, 9'd1, 32'h40, {4{$urandom}});
        run_until(7, 60, "drain");
        order_log.delete();
        push_pkt(0, 3'b010, 5'b00000, 1, 9'd1, 32'h100, {4{$urandom}});
        push_pkt(1, 3'b010, 5'b00000, 1, 9'd1, 32'h200, {4{$urandom}});
        push_pkt(2, 3'b000, 5'b00000, 1, 9'd1, 32'h300, {4{$urandom}});
        run_until(2, 20, "starve");
        n_checks++;
        if (order_log.size() != 2 || order_log[0] != 0 || order_log[1] != 2) begin
            n_errors++;
            $display("FAIL starve_order: got %p required 0,2", order_log);
        end
        n_checks++;
        if (dut.credit_q[0] !== 8'd0) begin
            n_errors++;
            $display("FAIL starve_ph_zero: got %0d required 0", dut.credit_q[0]);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'b000);
            n_checks++;
            if (req_ready_o !== 4'b0000 || tlp_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL starve_blocked: ready %b valid %b required 0000 0", req_ready_o, tlp_valid_o);
            end
        end
        cycle(1'b1, 3'b001);
        cycle(1'b1, 3'b000);
        n_checks++;
        if (tlp_valid_o !== 1'b1 || grant_o !== 2'd1) begin
            n_errors++;
            $display("FAIL credit_return_grant: valid %b grant %0d required 1 1", tlp_valid_o, grant_o);
        end
        run_until(3, 10, "after_return");
    endtask

    task automatic test_ready_stall();
        logic [DW-1:0] base;
        do_reset();
        base = {$urandom, $urandom, $urandom, $urandom};
        push_pkt(0, 3'b010, 5'b00000, 4, 9'd16, 32'hABC0, base);
        push_pkt(2, 3'b000, 5'b00100, 1, 9'd1, 32'h10, {4{$urandom}});
        cycle(1'b1, 3'b000);
        cycle(1'b1, 3'b000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'b000);
            n_checks++;
            if (grant_o !== 2'd0 || tlp_valid_o !== 1'b1 || data_o !== base + 128'd1) begin
                n_errors++;
                $display("FAIL stall_hold: grant %0d valid %b data %h required 0 1 %h", grant_o, tlp_valid_o, data_o, base + 128'd1);
            end
        end
        run_until(2, 20, "stall");
        n_checks++;
        if (order_log.size() != 2 || order_log[0] != 0 || order_log[1] != 2) begin
            n_errors++;
            $display("FAIL stall_order: got %p required 0,2", order_log);
        end
    endtask

    task automatic test_credit_saturation();
        do_reset();
        for (int i = 0; i < 250; i++) cycle(1'b0, 3'b001);
        n_checks++;
        if (dut.credit_q[0] !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_255: got %0d required 255", dut.credit_q[0]);
        end
        push_pkt(0, 3'b010, 5'b00000, 1, 9'd1, 32'h0, {4{$urandom}});
        cycle(1'b0, 3'b001);
        n_checks++;
        if (dut.credit_q[0] !== 8'd255 || grant_o !== 2'd0 || tlp_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_dec_ret_ph: credit %0d valid %b required 255 1", dut.credit_q[0], tlp_valid_o);
        end
        cycle(1'b1, 3'b000);
        push_pkt(1, 3'b000, 5'b00000, 1, 9'd1, 32'h0, {4{$urandom}});
        cycle(1'b0, 3'b010);
        n_checks++;
        if (dut.credit_q[1] !== 8'd8 || grant_o !== 2'd1) begin
            n_errors++;
            $display("FAIL dec_ret_nph: credit %0d grant %0d required 8 1", dut.credit_q[1], grant_o);
        end
        run_until(2, 10, "sat");
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push_pkt(1, 3'b000, 5'b01010, 1, 9'd1, 32'h0, {4{$urandom}});
        run_until(1, 10, "pre_rst");
        push_pkt(0, 3'b010, 5'b00000, 4, 9'd16, 32'h2000, {4{$urandom}});
        cycle(1'b1, 3'b000);
        cycle(1'b1, 3'b000);
        cycle(1'b1, 3'b000);
        n_checks++;
        if (tlp_valid_o !== 1'b1 || dut.credit_q[0] !== 8'd7 || dut.rr_ptr_q !== 2'd2) begin
            n_errors++;
            $display("FAIL rst_mid_setup: valid %b ph %0d ptr %0d required 1 7 2", tlp_valid_o, dut.credit_q[0], dut.rr_ptr_q);
        end
        rst = 1'b1;
        cycle(1'b1, 3'b000);
        rst = 1'b0;
        n_checks++;
        if (tlp_valid_o !== 1'b0 || grant_o !== 2'd0 || dut.rr_ptr_q !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_mid_state: valid %b grant %0d ptr %0d required 0 0 0", tlp_valid_o, grant_o, dut.rr_ptr_q);
        end
        n_checks++;
        if ({dut.credit_q[0], dut.credit_q[1], dut.credit_q[2]} !== 24'h080808) begin
            n_errors++;
            $display("FAIL rst_mid_credits: got %h required 080808", {dut.credit_q[0], dut.credit_q[1], dut.credit_q[2]});
        end
        flush_reqs();
        order_log.delete();
    endtask

    task automatic test_random();
        int pushed, k, n, kind;
        logic [7:0] ft [6];
        ft[0] = 8'b010_00000; ft[1] = 8'b000_00000; ft[2] = 8'b000_00100;
        ft[3] = 8'b010_00100; ft[4] = 8'b000_01010; ft[5] = 8'b010_01010;
        do_reset();
        rand_gaps = 1'b1;
        pushed = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                n = $urandom_range(0, NUM_REQ - 1);
                kind = $urandom_range(0, 5);
                if (tail[n] - head[n] < MAXP) begin
                    push_pkt(n, ft[kind][7:5], ft[kind][4:0], $urandom_range(1, 4), 9'($urandom),
                             $urandom, {$urandom, $urandom, $urandom, $urandom});
                    pushed++;
                end
            end
            cycle($urandom_range(0, 3) != 0,
                  {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0});
        end
        k = 0;
        while (order_log.size() < pushed && k < 2000) begin
            cycle(1'b1, 3'b111);
            k++;
        end
        rand_gaps = 1'b0;
        n_checks++;
        if (order_log.size() != pushed) begin
            n_errors++;
            $display("FAIL random_complete: packets done %0d required %0d", order_log.size(), pushed);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; chk_en = 1'b0; rand_gaps = 1'b0;
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cred = '{8, 8, 8};
        rst = 1'b1; tlp_ready_i = 1'b0; credit_ret_i = '0;
        req_valid_i = '0; req_last_i = '0; req_fmt_i = '0; req_type_i = '0; req_tc_i = '0;
        req_length_i = '0; req_requestID_i = '0; req_addr_i = '0; req_data_i = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            head[n] = 0; tail[n] = 0; cur_beat[n] = 0; presenting[n] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_single_mwr();
        test_round_robin();
        test_credit_block();
        test_ready_stall();
        test_credit_saturation();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcie_tlp_tx_arbiter.md
# pcie_tlp_tx_arbiter

Transmit-side TLP scheduler in front of the PCIe block. Shares the single TLP output path between NUM_REQ requesters (AXI write path, AXI read path, APB config, completion engine). It applies round-robin arbitration, gated by per-class header flow-control credits, and holds each grant for a whole multi-beat packet.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_WIDTH, 128: payload beat width, in bits
- PH_INIT, 8: posted-header credits loaded at reset
- NPH_INIT, 8: non-posted-header credits loaded at reset
- CPLH_INIT, 8: completion-header credits loaded at reset
- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_ready_o  out  NUM_REQ  per-requester beat accept
- req_last_i  in  NUM_REQ  final beat of the packet
- req_fmt_i  in  NUM_REQ×3  header fmt, stable from first valid until last handshake
- req_type_i  in  NUM_REQ×5  header type, same stability rule
- req_tc_i  in  NUM_REQ×3  traffic class
- req_length_i  in  NUM_REQ×9  length in DW
- req_requestID_i  in  NUM_REQ×16  requester ID
- req_addr_i  in  NUM_REQ×32  address
- req_data_i  in  NUM_REQ×DATA_WIDTH  beat data
- credit_ret_i  in  3  one-cycle credit-return pulses: [0] PH, [1] NPH, [2] CPLH
- tlp_valid_o  out  1  output beat valid
- tlp_ready_i  in  1  downstream accept
- tlp_last_o  out  1  final beat
- header_fmt_o, header_type_o, header_tc_o, header_length_o, header_requestID_o  out  3/5/3/9/16  granted header
- addr_o  out  32  granted address
- data_o  out  DATA_WIDTH  granted beat
- grant_o  out  $clog2(NUM_REQ)  index of the current owner

## Operation
- Class decode, from the head fields:
  - POSTED: MWr (type 5'b00000, fmt[1]=1).
  - COMPLETION: type 5'b01010.
  - NON_POSTED: everything else (MRd, CfgRd/Wr, IO).
- Eligibility: req_valid_i[n] and credit counter of class(n) > 0.
- FSM states: IDLE, XFER.
  - IDLE → XFER when at least one requester is eligible. The winner comes from the round-robin search starting at rr_ptr. The winner's index is registered into grant, and its class credit is decremented on the same edge.
  - IDLE with no eligible requester: remain in IDLE.
  - XFER: the output mirrors requester grant combinationally. tlp_valid_o = req_valid_i[grant]. req_ready_o[grant] = tlp_ready_i. All other ready bits are 0.
  - XFER → IDLE on a handshake with tlp_last_o=1. On that edge rr_ptr ← grant+1, modulo NUM_REQ.
- Grant is sticky: no preemption mid-packet, whatever the other requests or credits do.
- Credit counters are 8 bits each:
  - Decrement and credit_ret_i pulse on the same class in the same cycle: counter unchanged.
  - A return saturates at 255.
  - A counter at 0 never decrements, because eligibility blocks it.
- Credit starvation: requesters of a zero-credit class are skipped, and other classes proceed. rr_ptr advances only on packet completion.
- A requester dropping valid mid-packet stalls the output (tlp_valid_o=0). It does not release the grant.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant 0, credits PH_INIT/NPH_INIT/CPLH_INIT, req_ready_o all 0, tlp_valid_o 0, tlp_last_o 0. All header/addr/data outputs are 0 in IDLE.
- Arbitration latency is 1 cycle: a request visible in cycle T drives tlp_valid_o in T+1.
- Back-to-back packets have one idle bubble cycle between them.
- Beat throughput in XFER is 1 per cycle; the data path is zero-latency (combinational mux).
- rst asserted mid-packet: the next edge forces IDLE and reloads credits. The partial packet is abandoned, and the downstream sees tlp_valid_o drop.
- tlp_valid_o, once high, stays high until handshake while req_valid_i[grant] holds. Requesters must obey AXI-style valid rules.

## Structure
- Shared package pcie_tlp_pkg holds:
  - tlp_class_e (POSTED, NON_POSTED, COMPLETION)
  - TLP fmt/type constants (MWR, MRD, CFGRD0, CFGWR0, CPL, CPLD)
  - tlp_hdr_t struct (fmt, type, tc, length, requestID)
  - class_of() decode function
- One sub-module, pcie_rr_arb: combinational round-robin pick. Inputs are an eligible mask and a pointer; outputs are a found flag and the winner index. It is reused by the receive-side completion scheduler.

## Test plan
- Single MWr from req0 (addr 0, length 4, one beat 4×32'h01234567, last) → tlp_valid_o one cycle after req_valid_i; outputs match the inputs; grant_o=0; PH credit 8→7.
- req0..req3 all valid with 2-beat MRd packets simultaneously → grants in order 0,1,2,3, each packet contiguous with one bubble between packets; NPH credit 8→4.
- PH_INIT=1, two MWr from req0 and req1 → req0 sent; req1 blocked (ready 0). A credit_ret_i[0] pulse → req1 granted the next cycle.
- tlp_ready_i low for 3 cycles mid-packet while req2 is also valid → req0 beats hold stable, and no switch to req2 occurs until last.
- Credit counter at 255 with a return pulse → stays 255. Decrement and return in the same cycle → unchanged.
- rst asserted on beat 2 of a 4-beat packet → the next cycle shows tlp_valid_o=0, state IDLE, credits reloaded, rr_ptr 0.
